systolic_pe: RTL and testbench

// - Signed fixed-point multiply-accumulate processing element, tiled into a systolic array.
// - Each enabled cycle it computes y_out = y_in + a_in*b (Qm.FRAC_BIT format).
// - It also forwards a_in to a_out, so the activation passes on to the neighbouring PE.
// - Outputs are registered: one pipeline stage per PE.

---
 rtl/systolic_pe_if.sv | 22 ++
 rtl/systolic_pe.sv | 62 ++++++
 tb/tb_systolic_pe.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/systolic_pe_if.sv
// rtl/systolic_pe_if.sv - operand/result bundle between a systolic PE and its neighbours
interface systolic_pe_if #(
    parameter int WIDTH = 16
);
    logic                    en;
    logic signed [WIDTH-1:0] a_in;
    logic signed [WIDTH-1:0] y_in;
    logic signed [WIDTH-1:0] b;
    logic signed [WIDTH-1:0] a_out;
    logic signed [WIDTH-1:0] y_out;
    logic                    valid_out;

    modport master (
        output en, a_in, y_in, b,
        input  a_out, y_out, valid_out
    );

    modport slave (
        input  en, a_in, y_in, b,
        output a_out, y_out, valid_out
    );
endinterface

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - signed fixed-point MAC processing element, one register stage
// Optional build macro PE_SATURATE_EN clamps the result instead of wrapping it.
module systolic_pe #(
    parameter int WIDTH    = 16,
    parameter int FRAC_BIT = 10
) (
    input logic          clk,
    input logic          rst,
    systolic_pe_if.slave pe
);
    localparam int PW = 2 * WIDTH;

    logic signed [PW-1:0]    a_ext;
    logic signed [PW-1:0]    b_ext;
    logic signed [PW-1:0]    y_ext;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    quot;
    logic signed [PW-1:0]    sum;
    logic        [WIDTH-1:0] result;

    // Everything is carried at 2*WIDTH so the add can never overflow before reduction.
    always_comb begin
        a_ext = {{WIDTH{pe.a_in[WIDTH-1]}}, pe.a_in};
        b_ext = {{WIDTH{pe.b[WIDTH-1]}}, pe.b};
        y_ext = {{WIDTH{pe.y_in[WIDTH-1]}}, pe.y_in};
        prod  = a_ext * b_ext;
        quot  = prod >>> FRAC_BIT;
        sum   = quot + y_ext;
    end

`ifdef PE_SATURATE_EN
    // In range exactly when the bits from WIDTH-1 upward are all copies of the sign.
    always_comb begin
        result = sum[WIDTH-1:0];
        if (sum[PW-1:WIDTH-1] != {(WIDTH+1){1'b0}} &&
            sum[PW-1:WIDTH-1] != {(WIDTH+1){1'b1}}) begin
            if (sum[PW-1])
                result = {1'b1, {(WIDTH-1){1'b0}}};
            else
                result = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    logic [WIDTH-1:0] sum_unused_hi;

    assign {sum_unused_hi, result} = sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pe.a_out     <= '0;
            pe.y_out     <= '0;
            pe.valid_out <= 1'b0;
        end else if (pe.en) begin
            pe.a_out     <= pe.a_in;
            pe.y_out     <= result;
            pe.valid_out <= 1'b1;
        end else begin
            pe.valid_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_systolic_pe.sv
// tb/tb_systolic_pe.sv - self-checking bench for systolic_pe (honours PE_SATURATE_EN)
module tb_systolic_pe;
    localparam int W = 16;
    localparam int F = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    systolic_pe_if #(.WIDTH(W)) pe_bus ();

    systolic_pe #(.WIDTH(W), .FRAC_BIT(F)) dut (
        .clk (clk),
        .rst (rst),
        .pe  (pe_bus)
    );

    // Reference arithmetic: exact integer product, floor-divide by 2^F, add, then reduce.
    function automatic logic [15:0] mac_ref(input logic [15:0] a, input logic [15:0] y,
                                            input logic [15:0] bw);
        longint p;
        longint s;
        logic [63:0] s_bits;
        p = longint'($signed(a)) * longint'($signed(bw));
        s = (p >>> F) + longint'($signed(y));
`ifdef PE_SATURATE_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        s_bits = s;
        return s_bits[15:0];
    endfunction

    logic [15:0] exp_a;
    logic [15:0] exp_y;
    logic        exp_v;
    logic        model_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_a      <= 16'h0;
            exp_y      <= 16'h0;
            exp_v      <= 1'b0;
            model_live <= 1'b1;
        end else if (pe_bus.en) begin
            exp_a <= pe_bus.a_in;
            exp_y <= mac_ref(pe_bus.a_in, pe_bus.y_in, pe_bus.b);
            exp_v <= 1'b1;
        end else begin
            exp_v <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            chk("model_a_out", pe_bus.a_out, exp_a);
            chk("model_y_out", pe_bus.y_out, exp_y);
            chk("model_valid", {15'h0, pe_bus.valid_out}, {15'h0, exp_v});
        end
    end

    task automatic drive(input logic e, input logic [15:0] a, input logic [15:0] y,
                         input logic [15:0] bw);
        pe_bus.en   = e;
        pe_bus.a_in = a;
        pe_bus.y_in = y;
        pe_bus.b    = bw;
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [15:0] a,
                              input logic [15:0] y, input logic v);
        chk({name, "_a"}, pe_bus.a_out, a);
        chk({name, "_y"}, pe_bus.y_out, y);
        chk({name, "_v"}, {15'h0, pe_bus.valid_out}, {15'h0, v});
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 16'h1111, 16'h2222, 16'h3333);
        drive(1'b1, 16'h1111, 16'h2222, 16'h3333);
        expect_out("reset", 16'h0000, 16'h0000, 1'b0);

        rst = 1'b0;
        drive(1'b1, 16'h0200, 16'h0200, 16'h0400);
        expect_out("basic", 16'h0200, 16'h0400, 1'b1);

        drive(1'b1, 16'h02A1, 16'hFB86, 16'h16BC);
        expect_out("mixed", 16'h02A1, 16'h0A77, 1'b1);

        drive(1'b1, 16'h7FFF, 16'h0000, 16'h7FFF);
`ifdef PE_SATURATE_EN
        expect_out("ovf_pos", 16'h7FFF, 16'h7FFF, 1'b1);
`else
        expect_out("ovf_pos", 16'h7FFF, 16'hFFC0, 1'b1);
`endif

        drive(1'b1, 16'h8000, 16'h8000, 16'h7FFF);
`ifdef PE_SATURATE_EN
        expect_out("ovf_neg", 16'h8000, 16'h8000, 1'b1);
`else
        expect_out("ovf_neg", 16'h8000, 16'h8020, 1'b1);
`endif

        drive(1'b1, 16'h0200, 16'h0200, 16'h0400);
        drive(1'b0, 16'h1234, 16'h5678, 16'h1111);
        expect_out("hold", 16'h0200, 16'h0400, 1'b0);
        drive(1'b0, 16'h4321, 16'h0001, 16'h7777);
        expect_out("hold2", 16'h0200, 16'h0400, 1'b0);

        drive(1'b1, 16'hFFFF, 16'h0000, 16'h0001);
        expect_out("floor", 16'hFFFF, 16'hFFFF, 1'b1);

        drive(1'b1, 16'hFC00, 16'h0100, 16'hF800);
        expect_out("negneg", 16'hFC00, 16'h0900, 1'b1);

        drive(1'b1, 16'h0000, 16'h0000, 16'h0000);
        expect_out("zero", 16'h0000, 16'h0000, 1'b1);

        drive(1'b1, 16'h0200, 16'h0200, 16'h0400);
        rst = 1'b1;
        drive(1'b1, 16'h1234, 16'h1234, 16'h1234);
        expect_out("rst_prio", 16'h0000, 16'h0000, 1'b0);

        rst = 1'b0;
        drive(1'b1, 16'hC000, 16'h7000, 16'h2000);
        drive(1'b1, 16'h0001, 16'h7FFF, 16'h7FFF);
        drive(1'b1, 16'h8000, 16'h0000, 16'h8000);
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
